// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port: one request at a time, completing on req && ready.
interface mips_multicycle_core_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle RV32I-subset core sharing one memory port for fetch, load and store.
// Sequences each instruction through FETCH/DECODE/EXEC/[MEM]/[WB]; illegal encodings halt.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_core_if.master mem,
    output logic [31:0]            Result,
    output logic                   retire,
    output logic                   halted
);
    localparam int RW = (NREG == 16) ? 4 : 5;

    typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        oldpc;
    logic [31:0]        ir;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic [31:0]        aluout;
    logic [31:0]        mdr;
    logic [31:0]        rf [NREG];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       is_load, is_store, is_op, is_opi, is_br, is_jal;
    logic       use_rs1, use_rs2, use_rd, reg_bad, legal, taken;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_j, op_b;
    logic [31:0] exec_val, br_pc, wb_val;

    function automatic logic [31:0] alu(input logic [2:0] fn, input logic sub,
                                        input logic signed [31:0] x, input logic signed [31:0] y);
        case (fn)
            3'b000:  return sub ? x - y : x + y;
            3'b010:  return {31'b0, x < y};
            3'b110:  return x | y;
            3'b111:  return x & y;
            default: return '0;
        endcase
    endfunction

    // Low address bits are forced to zero so every access is word aligned.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] x);
        logic [31:0] y;
        y = x & 32'hFFFF_FFFC;
        return y[ADDR_W-1:0];
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        is_load = 1'b0; is_store = 1'b0; is_op = 1'b0; is_opi = 1'b0; is_br = 1'b0; is_jal = 1'b0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
        case (opcode)
            7'b0000011: begin is_load  = (f3 == 3'b010); use_rs1 = 1'b1; use_rd  = 1'b1; end
            7'b0100011: begin is_store = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110011: begin
                is_op = ((f7 == 7'b0000000) && (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111))
                     || ((f7 == 7'b0100000) && (f3 == 3'b000));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            7'b0010011: begin
                is_opi  = (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            7'b1100011: begin is_br = (f3 == 3'b000 || f3 == 3'b001); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1101111: begin is_jal = 1'b1; use_rd = 1'b1; end
            default: ;
        endcase
    end

    assign reg_bad = (NREG < 32) && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
    assign legal   = (is_load || is_store || is_op || is_opi || is_br || is_jal) && !reg_bad;

    assign op_b   = is_op ? b : imm_i;
    assign taken  = (a == b) ^ f3[0];
    assign br_pc  = taken ? oldpc + imm_b : pc;
    assign wb_val = is_load ? mdr : aluout;

    always_comb begin
        if (is_jal)        exec_val = pc;
        else if (is_load)  exec_val = a + imm_i;
        else if (is_store) exec_val = a + imm_s;
        else               exec_val = alu(f3, is_op && f7[5], a, op_b);
    end

    // Control, architectural state and registered memory/retire outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            Result        <= '0;
            retire        <= 1'b0;
            halted        <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                BOOT: begin
                    state        <= FETCH;
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= word_addr(pc);
                end
                FETCH: if (mem.mem_ready) begin
                    pc          <= pc + 32'd4;
                    mem.mem_req <= 1'b0;
                    state       <= DECODE;
                end
                DECODE: begin
                    if (!legal) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        state        <= MEM;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= is_store;
                        mem.mem_addr <= word_addr(exec_val);
                        if (is_store) mem.mem_wdata <= b;
                    end else if (is_br) begin
                        pc           <= br_pc;
                        retire       <= 1'b1;
                        state        <= FETCH;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= word_addr(br_pc);
                    end else begin
                        if (is_jal) pc <= oldpc + imm_j;
                        state <= WB;
                    end
                end
                MEM: if (mem.mem_ready) begin
                    if (mem.mem_we) begin
                        // Store done: roll straight into the next fetch without dropping req.
                        retire       <= 1'b1;
                        state        <= FETCH;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= word_addr(pc);
                    end else begin
                        mem.mem_req  <= 1'b0;
                        state        <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) rf[rd[RW-1:0]] <= wb_val;
                    Result       <= wb_val;
                    retire       <= 1'b1;
                    state        <= FETCH;
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= word_addr(pc);
                end
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

    // Datapath latches: always reloaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        case (state)
            FETCH: if (mem.mem_ready) begin
                ir    <= mem.mem_rdata;
                oldpc <= pc;
            end
            DECODE: begin
                a <= rf[rs1[RW-1:0]];
                b <= rf[rs2[RW-1:0]];
            end
            EXEC: aluout <= exec_val;
            MEM:  if (mem.mem_ready) mdr <= mem.mem_rdata;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: per-instruction expectations (fetch address, Result, latency) are queued
// with each program and popped as the core fetches and retires.
module tb_mips_multicycle_core;
    localparam logic [6:0] OP_I = 7'h13;
    localparam logic [6:0] OP_L = 7'h03;

    typedef struct packed {
        logic [31:0] fetch;
        logic [31:0] res;
        logic [7:0]  lat;
        logic        retires;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] result, result16;
    logic        retire, retire16, halted, halted16;

    mips_multicycle_core_if #(.ADDR_W(32)) bus ();
    mips_multicycle_core_if #(.ADDR_W(32)) bus16 ();

    mips_multicycle_core #(.RESET_PC(32'h0), .NREG(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .mem(bus), .Result(result), .retire(retire), .halted(halted));

    mips_multicycle_core #(.RESET_PC(32'h0), .NREG(16), .ADDR_W(32)) dut16 (
        .clk(clk), .reset(reset), .mem(bus16), .Result(result16), .retire(retire16), .halted(halted16));

    logic [31:0] img [0:127];
    logic [31:0] dword = 32'h0;
    int          waits = 0;
    int          wcnt = 0;
    int          wr_count = 0;
    int          cyc = 0;
    logic [31:0] i16_a, i16_b;

    assign bus.mem_ready   = bus.mem_req && (wcnt >= waits);
    assign bus.mem_rdata   = (bus.mem_addr == 32'h100) ? dword : img[bus.mem_addr[8:2]];
    assign bus16.mem_ready = 1'b1;
    assign bus16.mem_rdata = (bus16.mem_addr == 32'h0) ? i16_a : i16_b;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_ret = 0;
    int          ret16 = 0;
    int          fcyc = 0;
    int          st_cycles = 0;
    bit          busy = 1'b0;
    logic [31:0] st_addr_exp = 32'h100;
    logic [31:0] st_data_exp = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        logic [31:0] s2, s1, d;
        s2 = rs2; s1 = rs1; d = rd;
        return {f7, s2[4:0], s1[4:0], f3, d[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        logic [31:0] im, s1, d;
        im = imm; s1 = rs1; d = rd;
        return {im[11:0], s1[4:0], f3, d[4:0], op};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        logic [31:0] im, s2, s1;
        im = imm; s2 = rs2; s1 = rs1;
        return {im[11:5], s2[4:0], s1[4:0], 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] im, s2, s1;
        im = imm; s2 = rs2; s1 = rs1;
        return {im[12], im[10:5], s2[4:0], s1[4:0], f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [31:0] im, d;
        im = imm; d = rd;
        return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] instr);
        img[addr[8:2]] = instr;
    endtask

    task automatic expect_ins(input logic [31:0] fetch, input logic [31:0] res, input int lat, input bit rets);
        exp_t e;
        e.fetch = fetch; e.res = res; e.lat = 8'(lat); e.retires = rets;
        exp_q.push_back(e);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 128; i++) img[i] = 32'h0;
    endtask

    task automatic wait_halt(input string tag, input int limit);
        for (int i = 0; i < limit && !halted; i++) @(negedge clk);
        check_eq(tag, {31'b0, halted}, 32'd1);
    endtask

    task automatic check_quiet_after_halt(input string tag);
        int reqs, rc;
        reqs = 0; rc = n_ret;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_req) reqs++;
        end
        check_eq({tag, "_req_idle"}, reqs, 0);
        check_eq({tag, "_no_retire"}, n_ret - rc, 0);
        check_eq({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   wc0;
        reset = 1'b0;
        waits = 0;
        clear_img();
        i16_a = i_t(3, 0, 3'b000, 15, OP_I);
        i16_b = r_t(7'h00, 2, 1, 3'b000, 17);

        fork
            forever begin
                @(posedge clk);
                cyc <= cyc + 1;
                if (!reset)                             wcnt <= 0;
                else if (bus.mem_req && bus.mem_ready) begin
                    wcnt <= 0;
                    if (bus.mem_we) begin
                        wr_count <= wr_count + 1;
                        if (bus.mem_addr == 32'h100) dword <= bus.mem_wdata;
                    end
                end else if (bus.mem_req)               wcnt <= wcnt + 1;
                else                                    wcnt <= 0;
            end
            forever begin
                @(negedge clk);
                if (!reset) begin
                    busy = 1'b0;
                    st_cycles = 0;
                    ret16 = 0;
                end else begin
                    if (retire16) ret16++;
                    if (retire) begin
                        n_ret++;
                        if (exp_q.size() == 0) check_eq("spurious_retire", 32'd1, 32'd0);
                        else begin
                            e = exp_q.pop_front();
                            check_eq("result", result, e.res);
                            check_eq("latency", cyc - fcyc, {24'b0, e.lat});
                        end
                        busy = 1'b0;
                    end
                    if (bus.mem_req && bus.mem_ready && !bus.mem_we && !busy) begin
                        busy = 1'b1;
                        fcyc = cyc;
                        if (exp_q.size() == 0) check_eq("extra_fetch", bus.mem_addr, 32'hFFFF_FFFF);
                        else begin
                            check_eq("fetch_addr", bus.mem_addr, exp_q[0].fetch);
                            if (!exp_q[0].retires) void'(exp_q.pop_front());
                        end
                    end
                    if (bus.mem_req && bus.mem_we) begin
                        st_cycles++;
                        check_eq("st_addr", bus.mem_addr, st_addr_exp);
                        check_eq("st_data", bus.mem_wdata, st_data_exp);
                        if (bus.mem_ready) begin
                            check_eq("st_hold", st_cycles, waits + 1);
                            st_cycles = 0;
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_req",    {31'b0, bus.mem_req}, 32'd0);
        check_eq("rst_we",     {31'b0, bus.mem_we},  32'd0);
        check_eq("rst_addr",   bus.mem_addr,         32'd0);
        check_eq("rst_wdata",  bus.mem_wdata,        32'd0);
        check_eq("rst_result", result,               32'd0);
        check_eq("rst_retire", {31'b0, retire},      32'd0);
        check_eq("rst_halted", {31'b0, halted},      32'd0);

        // Run A: ALU, x0, branches, jal, zero wait states
        put(32'h00, i_t(5, 0, 3'b000, 1, OP_I));           expect_ins(32'h00, 32'h5, 4, 1);
        put(32'h04, i_t(-3, 0, 3'b000, 2, OP_I));          expect_ins(32'h04, 32'hFFFF_FFFD, 4, 1);
        put(32'h08, r_t(7'h00, 2, 1, 3'b000, 3));          expect_ins(32'h08, 32'h2, 4, 1);
        put(32'h0C, r_t(7'h00, 1, 2, 3'b010, 4));          expect_ins(32'h0C, 32'h1, 4, 1);
        put(32'h10, b_t(8, 1, 1, 3'b001));                 expect_ins(32'h10, 32'h1, 3, 1);
        put(32'h14, i_t(7, 0, 3'b000, 0, OP_I));           expect_ins(32'h14, 32'h7, 4, 1);
        put(32'h18, r_t(7'h00, 0, 0, 3'b000, 8));          expect_ins(32'h18, 32'h0, 4, 1);
        put(32'h1C, i_t(-2, 2, 3'b010, 9, OP_I));          expect_ins(32'h1C, 32'h1, 4, 1);
        put(32'h20, j_t(16, 6));                           expect_ins(32'h20, 32'h24, 4, 1);
        put(32'h24, i_t(1, 0, 3'b000, 10, OP_I));
        put(32'h30, r_t(7'h00, 0, 6, 3'b000, 10));         expect_ins(32'h30, 32'h24, 4, 1);
        put(32'h34, r_t(7'h00, 1, 2, 3'b111, 11));         expect_ins(32'h34, 32'h5, 4, 1);
        put(32'h38, i_t(255, 2, 3'b111, 13, OP_I));        expect_ins(32'h38, 32'hFD, 4, 1);
        put(32'h3C, r_t(7'h20, 2, 1, 3'b000, 14));         expect_ins(32'h3C, 32'h8, 4, 1);
        put(32'h40, i_t(16, 1, 3'b110, 12, OP_I));         expect_ins(32'h40, 32'h15, 4, 1);
        put(32'h44, r_t(7'h00, 14, 11, 3'b110, 15));       expect_ins(32'h44, 32'hD, 4, 1);
        put(32'h48, b_t(8, 2, 1, 3'b001));                 expect_ins(32'h48, 32'hD, 3, 1);
        put(32'h4C, i_t(1, 0, 3'b000, 10, OP_I));
        expect_ins(32'h50, 32'h0, 0, 0);

        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("boot_req_low", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        check_eq("boot_fetch_req", {31'b0, bus.mem_req}, 32'd1);
        wait_halt("runA_halt", 400);
        check_quiet_after_halt("runA");
        check_eq("nreg16_halted", {31'b0, halted16}, 32'd1);
        check_eq("nreg16_retires", ret16, 1);
        check_eq("nreg16_result", result16, 32'h3);

        // Run B: store/load with two wait states, jal x0 and a backward beq
        @(negedge clk);
        reset = 1'b0;
        waits = 2;
        clear_img();
        st_addr_exp = 32'h100;
        st_data_exp = 32'h2;
        wc0 = wr_count;
        put(32'h00, i_t(2, 0, 3'b000, 3, OP_I));           expect_ins(32'h00, 32'h2, 4, 1);
        put(32'h04, s_t(256, 3, 0));                       expect_ins(32'h04, 32'h2, 6, 1);
        put(32'h08, i_t(256, 0, 3'b010, 5, OP_L));         expect_ins(32'h08, 32'h2, 7, 1);
        put(32'h0C, r_t(7'h00, 5, 5, 3'b000, 6));          expect_ins(32'h0C, 32'h4, 4, 1);
        put(32'h10, j_t(12, 0));                           expect_ins(32'h10, 32'h14, 4, 1);
        put(32'h1C, b_t(-8, 6, 6, 3'b000));                expect_ins(32'h1C, 32'h14, 3, 1);
        put(32'h14, i_t(9, 0, 3'b000, 7, OP_I));           expect_ins(32'h14, 32'h9, 4, 1);
        expect_ins(32'h18, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_halt("runB_halt", 600);
        check_quiet_after_halt("runB");
        check_eq("runB_writes", wr_count - wc0, 1);
        check_eq("runB_dword", dword, 32'h2);

        // Run C: reset asserted while a store is stalled
        @(negedge clk);
        reset = 1'b0;
        waits = 10;
        clear_img();
        st_data_exp = 32'h0;
        put(32'h00, s_t(256, 0, 0));
        expect_ins(32'h00, 32'h0, 6, 1);
        @(negedge clk);
        wc0 = wr_count;
        reset = 1'b1;
        for (int i = 0; i < 100 && !(bus.mem_req && bus.mem_we); i++) @(negedge clk);
        check_eq("abort_store_seen", {31'b0, bus.mem_req && bus.mem_we}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_req", {31'b0, bus.mem_req}, 32'd0);
        check_eq("abort_we",  {31'b0, bus.mem_we},  32'd0);
        repeat (15) @(negedge clk);
        check_eq("abort_no_write", wr_count - wc0, 0);
        check_eq("abort_dword", dword, 32'h2);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle core. A shared instruction/data memory port with a req/ready handshake replaces the separate instruction and data memories, and the control FSM sequences each instruction over 3–5 cycles plus memory wait states. It implements the same RV32I integer subset, and adds bne, jal, wait-state tolerance, a retire strobe and an illegal-instruction halt. Register file, ALU, immediate extension and PC logic are internal; the only external agent is the memory.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NREG, 32: architectural registers. Legal values are 16 (RV32E) or 32. With 16, any rs1/rs2/rd index ≥16 is illegal.
- ADDR_W, 32: mem_addr width. The PC is kept at 32 bits; mem_addr carries PC/ALU bits [ADDR_W-1:0].
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- mem_req, output, 1: memory access request.
- mem_we, output, 1: 1 = write (store), 0 = read (fetch or load).
- mem_addr, output, ADDR_W: byte address, word-aligned by construction.
- mem_wdata, output, 32: store data.
- mem_ready, input, 1: access completes in any cycle where mem_req && mem_ready.
- mem_rdata, input, 32: read data, valid in the completing cycle.
- Result, output, 32: last value written back (ALU result, load data or link address).
- retire, output, 1: one-cycle pulse per completed instruction.
- halted, output, 1: high once an illegal instruction has been decoded.

## Operation
- Supported instructions:
  - lw, sw (funct3 010).
  - R-type: add, sub, and, or, slt.
  - I-type: addi, andi, ori, slti.
  - beq, bne.
  - jal.
  - Immediates are sign-extended in I/S/B/J formats.
  - Anything else is illegal, including a wrong funct3/funct7, or a register index out of range when NREG=16.
- States and transitions:
  - BOOT → FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Wait until ready. On ready: IR←mem_rdata, OLDPC←PC, PC←PC+4. → DECODE.
  - DECODE: A←rf[rs1], B←rf[rs2]. Illegal → HALT, otherwise → EXEC.
  - EXEC, by instruction:
    - R/I: ALUOUT←result, → WB.
    - lw/sw: ALUOUT←A+imm, → MEM.
    - beq/bne: if taken, PC←OLDPC+imm. Retire. → FETCH.
    - jal: ALUOUT←PC (already OLDPC+4), PC←OLDPC+imm, → WB.
  - MEM: mem_req=1, mem_addr=ALUOUT, mem_we=1 for sw with mem_wdata=B. Wait until ready.
    - sw: retire, → FETCH.
    - lw: MDR←mem_rdata, → WB.
  - WB: rf[rd]←ALUOUT or MDR. Result←same value. Retire. → FETCH.
  - HALT: terminal. mem_req=0. Exit only by reset.
- x0 always reads 0. Writes to x0 are dropped, but Result still updates and retire still pulses.
- slt/slti are signed 32-bit compares. Add/sub wrap modulo 2^32. The PC wraps modulo 2^32.
- Branch/jal targets with nonzero bits [1:0] are not checked. The low two bits are forced to 0 on mem_addr.
- Memory rules:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.
  - mem_ready while mem_req=0 is ignored.

## Timing
- Reset values, while reset=0: state=BOOT, PC=RESET_PC, all rf entries 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Result=0, retire=0, halted=0.
- Reset assertion is asynchronous at any point, including mid-access. mem_req drops immediately and a pending store is abandoned.
- After reset release: BOOT takes one cycle, then FETCH.
- Cycle counts with zero wait states (mem_ready=1 while requested):

  | Instruction | Cycles |
  |---|---|
  | branch | 3 |
  | R/I | 4 |
  | sw | 4 |
  | jal | 4 |
  | lw | 5 |

  Each wait cycle at FETCH or MEM adds one.
- retire is registered. It is high in the cycle after the final state of the instruction, coincident with the next FETCH, and is the only pulse for that instruction.
- Result and rf update on the same edge, and before retire is seen high.
- halted is set on the edge leaving DECODE. retire is not pulsed for the illegal instruction.

## Test plan
- Reset/boot:
  - Hold reset=0: every output is 0.
  - Release reset: cycle 1 shows mem_req=0. Cycle 2 shows mem_req=1 and mem_addr=RESET_PC.
- ALU sequence, zero-wait: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1.
  - Fetch addresses 0, 4, 8, 12.
  - retire every 4 cycles.
  - Result values 5, 0xFFFFFFFD, 2, 1.
- Store then load with 2 wait cycles per access: sw x3,8(x0); lw x5,8(x0).
  - Store: mem_we=1, mem_addr=8, mem_wdata=2, all held 3 cycles.
  - x5=2 and Result=2.
  - Store retires 6 cycles after its fetch; load retires 7 cycles after its fetch.
- Branches:
  - beq x1,x1,-8 at 0x10 → next fetch 0x08, 3 cycles.
  - bne x1,x1,+8 at 0x10 → next fetch 0x14.
  - Writes to x0 (addi x0,x0,7) leave x0=0 while Result=7.
- jal x6,+16 at 0x20 → x6=0x24, Result=0x24, next fetch 0x30.
- Illegal and reset-abort:
  - Opcode 0x00 → halted=1, mem_req stays 0 indefinitely, no retire.
  - With NREG=16, add x17,x1,x2 → halted=1.
  - Assert reset during a stalled sw → mem_req=0 that cycle, and the memory is never written.
